axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
- AXI4-Lite initiator that turns single-cycle write/read command pulses into complete AXI4-Lite transactions.
- Drives the slave port of the AXI-to-APB bridge (aw/w/b/ar/r channels).
- Returns the completion response and read data to the command source (CPU stub, debug controller or bench driver).
- One outstanding transaction at a time; no bursts; strobes not supported (full-word writes only).

Parameters:
ADDR_W, 32, address width of addr/aw_addr/ar_addr
DATA_W, 32, data width of data/w_data/r_data/debug_rdata
TIMEOUT_CYC, 256, wait-state cycle limit before abort (used only when AXI_TIMEOUT_EN is defined)

Ports:
apb_axi_clk  input  1  system clock, all logic on rising edge
a_reset_n  input  1  asynchronous active-low reset
start_write  input  1  one-cycle pulse: begin write of data to addr
start_read  input  1  one-cycle pulse: begin read from addr
addr  input  ADDR_W  command address, sampled with start_*
data  input  DATA_W  write data, sampled with start_write
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle completion pulse
cmd_resp  output  2  BRESP/RRESP of last completed transaction (2'b11 on timeout)
debug_rdata  output  DATA_W  read data of last completed read
timeout_err  output  1  one-cycle pulse on watchdog abort (tied 0 without macro)
aw_addr  output  ADDR_W  write address
aw_valid  output  1  write address valid
aw_ready  input  1  write address ready
w_data  output  DATA_W  write data
w_valid  output  1  write data valid
w_ready  input  1  write data ready
b_valid  input  1  write response valid
b_ready  output  1  write response ready
b_resp  input  2  write response
ar_addr  output  ADDR_W  read address
ar_valid  output  1  read address valid
ar_ready  input  1  read address ready
r_valid  input  1  read data valid
r_ready  output  1  read data ready
r_data  input  DATA_W  read data
r_resp  input  2  read response

Behaviour:
- Reset (async, a_reset_n=0): state IDLE. All valid/ready outputs, busy, done and timeout_err are 0. aw_addr, w_data, ar_addr, debug_rdata are 0. cmd_resp is 2'b00. Reset mid-transaction drops all valids immediately; no completion is reported.
- All outputs are registered.
- States: IDLE, WR_AW_W, WR_RESP, RD_AR, RD_DATA.
- IDLE:
  - start_write at edge N: latch addr/data. At N+1, aw_valid=w_valid=1, busy=1; go to WR_AW_W.
  - start_read at edge N: latch addr. At N+1, ar_valid=1, busy=1; go to RD_AR.
  - Both starts in the same cycle: write wins and the read is dropped.
- start_* while busy is ignored; no queueing.
- WR_AW_W:
  - aw_valid and w_valid each clear on the cycle after their own handshake (valid&ready), independently, in either order or together.
  - Payload is held stable while valid is high.
  - When both handshakes are complete, go to WR_RESP with b_ready=1.
- WR_RESP: on b_valid&b_ready, clear b_ready, capture b_resp into cmd_resp, pulse done and clear busy next cycle, return to IDLE.
- RD_AR: ar_valid held until ar_ready. Next cycle ar_valid=0, r_ready=1; go to RD_DATA.
- RD_DATA: on r_valid&r_ready, capture r_data into debug_rdata and r_resp into cmd_resp, clear r_ready, pulse done, return to IDLE. debug_rdata is captured even on SLVERR.
- Minimum latency with all readys and responses immediate: write 4 cycles start-to-done, read 4 cycles.
- A new start is accepted in the same cycle done is high, because state is IDLE then.
- b_valid/r_valid arriving outside their wait state are ignored (ready is low).

Optional Feature:
- Macro: AXI_TIMEOUT_EN.
- With the macro defined:
  - A counter resets on entering each non-IDLE state and on every handshake.
  - If the count reaches TIMEOUT_CYC, all valids/readys are deasserted and the FSM returns to IDLE.
  - On abort: done and timeout_err pulse, cmd_resp=2'b11, debug_rdata unchanged.
  - This deliberately drops a valid before ready and is for debug/bring-up only.
- Without the macro: no counter, timeout_err tied 0, waits are unbounded.

Test Plan:
- Write addr=0x3000_1000 data=0x0000_00A5, aw_ready=w_ready=1, b_valid one cycle after handshake, b_resp=0 -> aw_addr=0x3000_1000, w_data=0xA5, done at cycle 4, cmd_resp=2'b00.
- Same write with w_ready immediate and aw_ready delayed 3 cycles -> w_valid drops after 1 cycle, aw_valid high 4 cycles, b_ready only after both handshakes, done once.
- Read addr=0x3000_1004, r_data=0xDEAD_BEEF, r_resp=2'b00 -> ar_valid until ar_ready, debug_rdata=0xDEAD_BEEF, done pulse, busy low.
- Read addr=0x2000_0000 returning r_resp=2'b10 -> cmd_resp=2'b10, debug_rdata updated. Then start_write and start_read in the same cycle -> only the write is issued, ar_valid stays 0.
- a_reset_n low for 2 cycles while in RD_DATA -> r_ready, busy, done all 0 at once. A subsequent read completes normally.
- With AXI_TIMEOUT_EN and TIMEOUT_CYC=16, aw_ready held 0 -> after 16 cycles aw_valid/w_valid clear, done=timeout_err=1 for one cycle, cmd_resp=2'b11.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite single-outstanding initiator: start_write/start_read pulses become full AXI4-Lite transactions.
// Optional watchdog abort of stalled transactions when AXI_TIMEOUT_EN is defined.
module axi_lite_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              apb_axi_clk,
  input  logic              a_reset_n,
  input  logic              start_write,
  input  logic              start_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        cmd_resp,
  output logic [DATA_W-1:0] debug_rdata,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] aw_addr,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [1:0]        b_resp,
  output logic [ADDR_W-1:0] ar_addr,
  output logic              ar_valid,
  input  logic              ar_ready,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp
);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_RESP, RD_AR, RD_DATA} state_t;
  state_t state, state_nxt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_fin, w_fin, tmo;

  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;
  assign b_hs  = b_valid & b_ready;
  assign ar_hs = ar_valid & ar_ready;
  assign r_hs  = r_valid & r_ready;
  // A write channel is finished once its valid has dropped or is handshaking now.
  assign aw_fin = ~aw_valid | aw_ready;
  assign w_fin  = ~w_valid | w_ready;

  logic              aw_valid_d, w_valid_d, b_ready_d, ar_valid_d, r_ready_d;
  logic              busy_d, done_d;
  logic [1:0]        cmd_resp_d;
  logic [DATA_W-1:0] debug_rdata_d, w_data_d;
  logic [ADDR_W-1:0] aw_addr_d, ar_addr_d;

  always_ff @(posedge apb_axi_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state       <= IDLE;
      aw_valid    <= 1'b0;
      w_valid     <= 1'b0;
      b_ready     <= 1'b0;
      ar_valid    <= 1'b0;
      r_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_resp    <= 2'b00;
      debug_rdata <= '0;
      aw_addr     <= '0;
      w_data      <= '0;
      ar_addr     <= '0;
    end else begin
      state       <= state_nxt;
      aw_valid    <= aw_valid_d;
      w_valid     <= w_valid_d;
      b_ready     <= b_ready_d;
      ar_valid    <= ar_valid_d;
      r_ready     <= r_ready_d;
      busy        <= busy_d;
      done        <= done_d;
      cmd_resp    <= cmd_resp_d;
      debug_rdata <= debug_rdata_d;
      aw_addr     <= aw_addr_d;
      w_data      <= w_data_d;
      ar_addr     <= ar_addr_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_write) state_nxt = WR_AW_W;
               else if (start_read) state_nxt = RD_AR;
      WR_AW_W: if (aw_fin && w_fin) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = IDLE;
      RD_AR:   if (ar_hs) state_nxt = RD_DATA;
      RD_DATA: if (r_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (tmo) state_nxt = IDLE;
  end

  always_comb begin
    aw_valid_d    = aw_valid;
    w_valid_d     = w_valid;
    b_ready_d     = b_ready;
    ar_valid_d    = ar_valid;
    r_ready_d     = r_ready;
    busy_d        = busy;
    done_d        = 1'b0;
    cmd_resp_d    = cmd_resp;
    debug_rdata_d = debug_rdata;
    aw_addr_d     = aw_addr;
    w_data_d      = w_data;
    ar_addr_d     = ar_addr;
    case (state)
      IDLE: begin
        // Write has priority; a simultaneous read request is dropped.
        if (start_write) begin
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          busy_d     = 1'b1;
          aw_addr_d  = addr;
          w_data_d   = data;
        end else if (start_read) begin
          ar_valid_d = 1'b1;
          busy_d     = 1'b1;
          ar_addr_d  = addr;
        end
      end
      WR_AW_W: begin
        if (aw_hs) aw_valid_d = 1'b0;
        if (w_hs)  w_valid_d  = 1'b0;
        if (aw_fin && w_fin) b_ready_d = 1'b1;
      end
      WR_RESP: if (b_hs) begin
        b_ready_d  = 1'b0;
        cmd_resp_d = b_resp;
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end
      RD_AR: if (ar_hs) begin
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b1;
      end
      RD_DATA: if (r_hs) begin
        r_ready_d     = 1'b0;
        cmd_resp_d    = r_resp;
        debug_rdata_d = r_data;
        done_d        = 1'b1;
        busy_d        = 1'b0;
      end
      default: ;
    endcase
    if (tmo) begin
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      b_ready_d  = 1'b0;
      ar_valid_d = 1'b0;
      r_ready_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      cmd_resp_d = 2'b11;
    end
  end

`ifdef AXI_TIMEOUT_EN
  // Watchdog counts stall cycles; any handshake or a state entry restarts it.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             any_hs;

  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign tmo    = (state != IDLE) && !any_hs && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge apb_axi_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo;
      if (state == IDLE || any_hs || tmo) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  // No watchdog: the expression is constant false and waits are unbounded.
  assign tmo         = (TIMEOUT_CYC < 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: transaction-timing model checked every cycle, directed plus random traffic.
module tb_axi_lite_cmd_master;
  localparam int AW = 32, DW = 32, TMO = 16;
  localparam int K_NONE = 0, K_WR = 1, K_RD = 2, K_TMO = 3;

  logic          apb_axi_clk = 1'b0;
  logic          a_reset_n = 1'b0;
  logic          start_write = 1'b0, start_read = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          busy, done, timeout_err;
  logic [1:0]    cmd_resp;
  logic [DW-1:0] debug_rdata;
  logic [AW-1:0] aw_addr, ar_addr;
  logic          aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [DW-1:0] w_data;
  logic          aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
  logic          b_valid = 1'b0, r_valid = 1'b0;
  logic [1:0]    b_resp = 2'b00, r_resp = 2'b00;
  logic [DW-1:0] r_data = '0;

  axi_lite_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .apb_axi_clk(apb_axi_clk), .a_reset_n(a_reset_n),
    .start_write(start_write), .start_read(start_read), .addr(addr), .data(data),
    .busy(busy), .done(done), .cmd_resp(cmd_resp), .debug_rdata(debug_rdata),
    .timeout_err(timeout_err),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
  );

  always #5 apb_axi_clk = ~apb_axi_clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit chk_en = 1'b0;
  always @(posedge apb_axi_clk) cyc <= cyc + 1;

  // Current transaction: start sampled at edge t_k0, slave delays da/dw/db in cycles.
  int            t_kind = K_NONE, t_k0 = 0, t_da = 0, t_dw = 0, t_db = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_data = '0, t_rdata = '0;
  logic [1:0]    t_resp = 2'b00;
  // Model of held outputs.
  logic [AW-1:0] m_awaddr = '0, m_araddr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [1:0]    m_resp = 2'b00;
  int n_awv = 0, n_wv = 0, n_arv = 0, n_done = 0, done_e = 0;
  int rk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit rb();
    return $urandom_range(1) == 1;
  endfunction

  // Edge at which the address/data phase is over and the response wait starts.
  function automatic int f_h(input int kind, input int k0, input int da, input int dw);
    if (kind == K_WR) return k0 + ((da > dw) ? da : dw) + 1;
    return k0 + da + 1;
  endfunction

  // Edge after which done is visible.
  function automatic int f_d(input int kind, input int k0, input int h, input int db);
    if (kind == K_TMO) return k0 + TMO;
    return h + db + 1;
  endfunction

  always @(negedge apb_axi_clk) begin : cmp
    int e, h, dn;
    bit wr, rd, tm, act;
    if (a_reset_n && chk_en) begin
      e  = cyc;
      wr = (t_kind == K_WR);
      rd = (t_kind == K_RD);
      tm = (t_kind == K_TMO);
      h  = f_h(t_kind, t_k0, t_da, t_dw);
      dn = f_d(t_kind, t_k0, h, t_db);
      act = (t_kind != K_NONE) && (e >= t_k0) && (e <= dn);
      if (act && e == t_k0) begin
        if (rd) m_araddr = t_addr;
        else begin m_awaddr = t_addr; m_wdata = t_data; end
      end
      if (act && e == dn) begin
        m_resp = tm ? 2'b11 : t_resp;
        if (rd) m_rdata = t_rdata;
      end
      chk("aw_valid", aw_valid, act && ((wr && e <= t_k0 + t_da) || (tm && e < dn)));
      chk("w_valid", w_valid, act && ((wr && e <= t_k0 + t_dw) || (tm && e < dn)));
      chk("b_ready", b_ready, act && wr && e >= h && e < dn);
      chk("ar_valid", ar_valid, act && rd && e <= t_k0 + t_da);
      chk("r_ready", r_ready, act && rd && e >= h && e < dn);
      chk("busy", busy, act && e < dn);
      chk("done", done, act && e == dn);
      chk("timeout_err", timeout_err, act && tm && e == dn);
      chk("aw_addr", aw_addr, m_awaddr);
      chk("w_data", w_data, m_wdata);
      chk("ar_addr", ar_addr, m_araddr);
      chk("cmd_resp", cmd_resp, m_resp);
      chk("debug_rdata", debug_rdata, m_rdata);
      if (aw_valid) n_awv++;
      if (w_valid) n_wv++;
      if (ar_valid) n_arv++;
      if (done) begin n_done++; done_e = e; end
    end
  end

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin
      start_write = 1'b0; start_read = 1'b0;
      aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
      b_valid = rb(); r_valid = rb();
      b_resp = 2'($urandom_range(3)); r_resp = 2'($urandom_range(3)); r_data = $urandom;
      @(posedge apb_axi_clk); #1;
    end
  endtask

  // Called just after a rising edge; returns in the cycle where done is visible.
  task automatic run_txn(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rdv, input int da, input int dw, input int db,
                         input logic [1:0] resp, input bit both, input bit noise);
    int k0, h, dn;
    start_write = (kind != K_RD);
    start_read  = (kind == K_RD) || both;
    addr = a; data = wd;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = noise && rb(); r_valid = noise && rb();
    @(posedge apb_axi_clk); #1;
    k0 = cyc;
    h  = f_h(kind, k0, da, dw);
    dn = f_d(kind, k0, h, db);
    t_kind = kind; t_k0 = k0; t_da = da; t_dw = dw; t_db = db;
    t_addr = a; t_data = wd; t_rdata = rdv; t_resp = resp;
    n_awv = 0; n_wv = 0; n_arv = 0; n_done = 0;
    for (int e = k0; e <= dn; e++) begin
      start_write = 1'b0; start_read = 1'b0;
      if (noise && e < dn && $urandom_range(3) == 0) begin
        start_write = rb(); start_read = rb(); addr = $urandom; data = $urandom;
      end
      aw_ready = (kind == K_WR) && (e == k0 + da);
      w_ready  = (kind == K_WR) && (e == k0 + dw);
      ar_ready = (kind == K_RD) && (e == k0 + da);
      b_valid  = (kind == K_WR) ? ((e == h + db) || (noise && e < h && rb())) : (noise && rb());
      r_valid  = (kind == K_RD) ? ((e == h + db) || (noise && e < h && rb())) : (noise && rb());
      b_resp   = (kind == K_WR && e == h + db) ? resp : 2'($urandom_range(3));
      r_resp   = (kind == K_RD && e == h + db) ? resp : 2'($urandom_range(3));
      r_data   = (kind == K_RD && e == h + db) ? rdv : $urandom;
      if (e < dn) begin @(posedge apb_axi_clk); #1; end
    end
    start_write = 1'b0; start_read = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; r_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(posedge apb_axi_clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valids", {aw_valid, w_valid, b_ready, ar_valid, r_ready, timeout_err}, 0);
    chk("rst_cmd_resp", cmd_resp, 0);
    chk("rst_payload", {aw_addr, w_data, ar_addr, debug_rdata}, 0);
    a_reset_n = 1'b1;
    chk_en = 1'b1;
    idle_n(2);

    // Minimum-latency write: done in the 4th cycle counting the start cycle.
    run_txn(K_WR, 32'h3000_1000, 32'h0000_00A5, '0, 0, 0, 0, 2'b00, 1'b0, 1'b0);
    chk("t1_aw_addr", aw_addr, 32'h3000_1000);
    chk("t1_w_data", w_data, 32'h0000_00A5);
    chk("t1_done", done, 1);
    idle_n(1);
    chk("t1_latency", done_e - t_k0 + 2, 4);
    chk("t1_cmd_resp", cmd_resp, 2'b00);

    // aw_ready late by 3 cycles, w_ready immediate.
    run_txn(K_WR, 32'h3000_1000, 32'h0000_00A5, '0, 3, 0, 0, 2'b00, 1'b0, 1'b0);
    idle_n(1);
    chk("t2_aw_cycles", n_awv, 4);
    chk("t2_w_cycles", n_wv, 1);
    chk("t2_done_count", n_done, 1);

    // Read with delayed ar_ready.
    run_txn(K_RD, 32'h3000_1004, '0, 32'hDEAD_BEEF, 2, 0, 1, 2'b00, 1'b0, 1'b0);
    chk("t3_busy_at_done", busy, 0);
    idle_n(1);
    chk("t3_rdata", debug_rdata, 32'hDEAD_BEEF);
    chk("t3_ar_cycles", n_arv, 3);
    chk("t3_done_count", n_done, 1);

    // SLVERR read still updates debug_rdata; then simultaneous starts.
    run_txn(K_RD, 32'h2000_0000, '0, 32'h1234_5678, 0, 0, 0, 2'b10, 1'b0, 1'b0);
    idle_n(1);
    chk("t4_cmd_resp", cmd_resp, 2'b10);
    chk("t4_rdata", debug_rdata, 32'h1234_5678);
    run_txn(K_WR, 32'h3000_2000, 32'h55AA_55AA, '0, 0, 0, 0, 2'b00, 1'b1, 1'b0);
    idle_n(1);
    chk("t4_both_ar_cycles", n_arv, 0);
    chk("t4_both_ar_addr", ar_addr, 32'h2000_0000);

    // Async reset while waiting in the read-data phase.
    start_read = 1'b1; addr = 32'h3000_1008;
    @(posedge apb_axi_clk); #1;
    start_read = 1'b0; ar_ready = 1'b1;
    t_kind = K_RD; t_k0 = cyc; t_da = 0; t_dw = 0; t_db = 20;
    t_addr = 32'h3000_1008; t_rdata = '0; t_resp = 2'b00;
    @(posedge apb_axi_clk); #1;
    ar_ready = 1'b0;
    repeat (2) begin @(posedge apb_axi_clk); #1; end
    chk("t5_pre_r_ready", r_ready, 1);
    a_reset_n = 1'b0;
    #1;
    chk("t5_r_ready", r_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_rdata", debug_rdata, 0);
    t_kind = K_NONE;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_rdata = '0; m_resp = 2'b00;
    @(posedge apb_axi_clk);
    @(posedge apb_axi_clk); #1;
    a_reset_n = 1'b1;
    idle_n(1);
    run_txn(K_RD, 32'h3000_100C, '0, 32'hCAFE_F00D, 1, 0, 1, 2'b01, 1'b0, 1'b0);
    idle_n(1);
    chk("t5_after_rdata", debug_rdata, 32'hCAFE_F00D);
    chk("t5_after_resp", cmd_resp, 2'b01);
    chk("t5_after_done", n_done, 1);

`ifdef AXI_TIMEOUT_EN
    // Stalled write is aborted after TMO cycles of valid.
    run_txn(K_TMO, 32'h3000_3000, 32'h0000_0001, '0, 0, 0, 0, 2'b00, 1'b0, 1'b0);
    chk("t6_done", done, 1);
    chk("t6_timeout_err", timeout_err, 1);
    chk("t6_cmd_resp", cmd_resp, 2'b11);
    idle_n(1);
    chk("t6_aw_cycles", n_awv, 16);
    chk("t6_w_cycles", n_wv, 16);
    chk("t6_done_count", n_done, 1);
`endif

    // Random traffic with ignored noise on starts and responses.
    for (int i = 0; i < 80; i++) begin
      rk = rb() ? K_WR : K_RD;
      run_txn(rk, $urandom, $urandom, $urandom, $urandom_range(5), $urandom_range(5),
              $urandom_range(5), 2'($urandom_range(3)), ($urandom_range(7) == 0), 1'b1);
      idle_n($urandom_range(2));
    end
    idle_n(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
